// File: rtl/oflow_mem_buffer_ctrl.sv
// oflow_mem_buffer_ctrl
//
// Arbitrates one write port and one read port onto a single-access
// frame/offset feature buffer.
//
// Write side: each granted write stores a pair of features at two consecutive
// offsets (wr_ptr, wr_ptr+1) of the current frame. wr_full is raised once the
// last offset pair of the frame has been used. It stays raised until the next
// frame_start.
//
// Read side: a granted read either accesses the buffer, or, if the frame is
// older than the history window, is answered with an error. In both cases
// rd_valid pulses two cycles after the grant.
//
// Arbitration: a write wins a collision unless the read has already lost
// STARVE_LIMIT consecutive cycles. No grant is issued in a frame_start cycle.
//
// Buffer timing assumption: the buffer presents data_out_0/1 for the address
// registered on frame_num/offset_0/1 during the following cycle. That value is
// captured into rd_data_0/1 at the end of that cycle.
//
// Ports
//   clk, reset_N                    clock, asynchronous active-low reset
//   frame_start, cfg_history_frames new-frame pulse and history depth to apply
//   wr_req/wr_gnt, wr_data_0/1      write handshake and feature pair
//   wr_full                         no free offset pair left in current frame
//   rd_req/rd_gnt                   read handshake
//   rd_frame_num, rd_offset_0/1     read address
//   rd_valid, rd_err, rd_data_0/1   read response
//   cur_frame_num                   current frame number
//   frame_num, num_of_history_frames, data_in_0/1, offset_0/1, we
//                                   registered buffer-side request
//   data_out_0/1                    buffer read data

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef OFFSET_WIDTH
`define OFFSET_WIDTH 6
`endif
`ifndef TOTAL_FRAME_NUM_WIDTH
`define TOTAL_FRAME_NUM_WIDTH 8
`endif
`ifndef NUM_OF_HISTORY_FRAMES_WIDTH
`define NUM_OF_HISTORY_FRAMES_WIDTH 3
`endif

module oflow_mem_buffer_ctrl #(
  parameter int unsigned STARVE_LIMIT    = 4,
  parameter int unsigned DEFAULT_HISTORY = 5
) (
  input  logic                                     clk,
  input  logic                                     reset_N,
  input  logic                                     frame_start,
  input  logic [`NUM_OF_HISTORY_FRAMES_WIDTH-1:0]  cfg_history_frames,
  // write port
  input  logic                                     wr_req,
  output logic                                     wr_gnt,
  input  logic [`DATA_WIDTH-1:0]                   wr_data_0,
  input  logic [`DATA_WIDTH-1:0]                   wr_data_1,
  output logic                                     wr_full,
  // read port
  input  logic                                     rd_req,
  output logic                                     rd_gnt,
  input  logic [`TOTAL_FRAME_NUM_WIDTH-1:0]        rd_frame_num,
  input  logic [`OFFSET_WIDTH-1:0]                 rd_offset_0,
  input  logic [`OFFSET_WIDTH-1:0]                 rd_offset_1,
  output logic                                     rd_valid,
  output logic                                     rd_err,
  output logic [`DATA_WIDTH-1:0]                   rd_data_0,
  output logic [`DATA_WIDTH-1:0]                   rd_data_1,
  output logic [`TOTAL_FRAME_NUM_WIDTH-1:0]        cur_frame_num,
  // buffer side
  output logic [`TOTAL_FRAME_NUM_WIDTH-1:0]        frame_num,
  output logic [`NUM_OF_HISTORY_FRAMES_WIDTH-1:0]  num_of_history_frames,
  output logic [`DATA_WIDTH-1:0]                   data_in_0,
  output logic [`DATA_WIDTH-1:0]                   data_in_1,
  output logic [`OFFSET_WIDTH-1:0]                 offset_0,
  output logic [`OFFSET_WIDTH-1:0]                 offset_1,
  output logic                                     we,
  input  logic [`DATA_WIDTH-1:0]                   data_out_0,
  input  logic [`DATA_WIDTH-1:0]                   data_out_1
);

  localparam int unsigned DW  = `DATA_WIDTH;
  localparam int unsigned OW  = `OFFSET_WIDTH;
  localparam int unsigned TFW = `TOTAL_FRAME_NUM_WIDTH;
  localparam int unsigned NHW = `NUM_OF_HISTORY_FRAMES_WIDTH;
  // Wide enough to hold STARVE_LIMIT itself, never zero bits.
  localparam int unsigned SW  = $clog2(STARVE_LIMIT + 2);

  localparam logic [SW-1:0]  StarveMax = SW'(STARVE_LIMIT);
  localparam logic [OW-1:0]  LastPair  = {{(OW-1){1'b1}}, 1'b0};
  localparam logic [NHW-1:0] HistRst   = NHW'(DEFAULT_HISTORY);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [TFW-1:0] cur_frame_q, cur_frame_d;
  logic [OW-1:0]  wr_ptr_q, wr_ptr_d;
  logic           wr_full_q, wr_full_d;
  logic [NHW-1:0] hist_q, hist_d;
  logic [SW-1:0]  starve_q, starve_d;

  logic [TFW-1:0] frame_num_q, frame_num_d;
  logic [OW-1:0]  offset_0_q, offset_0_d;
  logic [OW-1:0]  offset_1_q, offset_1_d;
  logic [DW-1:0]  data_in_0_q, data_in_0_d;
  logic [DW-1:0]  data_in_1_q, data_in_1_d;
  logic           we_q, we_d;

  // Read pipeline: stage 1 is the buffer access cycle, stage 2 the response.
  logic           rd_p1_q;
  logic           rd_p1_err_q, rd_p1_err_d;
  logic           rd_valid_q;
  logic           rd_err_q, rd_err_d;
  logic [DW-1:0]  rd_data_0_q, rd_data_0_d;
  logic [DW-1:0]  rd_data_1_q, rd_data_1_d;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic           wr_ok;
  logic           rd_ok;
  logic           rd_prio;
  logic [TFW-1:0] rd_age;
  logic           rd_stale;

  always_comb begin
    wr_ok    = wr_req & ~wr_full_q & ~frame_start;
    rd_ok    = rd_req & ~frame_start;
    rd_prio  = (starve_q == StarveMax);
    wr_gnt   = wr_ok & ~(rd_ok & rd_prio);
    rd_gnt   = rd_ok & ~wr_gnt;
    // Modular subtraction gives the correct age across frame-number wrap.
    rd_age   = cur_frame_q - rd_frame_num;
    rd_stale = (32'(rd_age) > 32'(hist_q));
  end

  // Starvation counter: counts lost cycles of a pending read, saturating.
  always_comb begin
    starve_d = '0;
    if (rd_req && !rd_gnt) begin
      starve_d = rd_prio ? starve_q : starve_q + SW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Frame and write-pointer bookkeeping
  // --------------------------------------------------------------------------
  always_comb begin
    cur_frame_d = cur_frame_q;
    wr_ptr_d    = wr_ptr_q;
    wr_full_d   = wr_full_q;
    hist_d      = hist_q;
    if (frame_start) begin
      cur_frame_d = cur_frame_q + TFW'(1);
      wr_ptr_d    = '0;
      wr_full_d   = 1'b0;
      hist_d      = cfg_history_frames;
    end else if (wr_gnt) begin
      wr_ptr_d  = wr_ptr_q + OW'(2);
      wr_full_d = (wr_ptr_q == LastPair);
    end
  end

  // --------------------------------------------------------------------------
  // Buffer-side request, registered one cycle after the grant
  // --------------------------------------------------------------------------
  always_comb begin
    we_d        = 1'b0;
    frame_num_d = frame_num_q;
    offset_0_d  = offset_0_q;
    offset_1_d  = offset_1_q;
    data_in_0_d = data_in_0_q;
    data_in_1_d = data_in_1_q;
    if (wr_gnt) begin
      we_d        = 1'b1;
      frame_num_d = cur_frame_q;
      offset_0_d  = wr_ptr_q;
      offset_1_d  = wr_ptr_q + OW'(1);
      data_in_0_d = wr_data_0;
      data_in_1_d = wr_data_1;
    end else if (rd_gnt && !rd_stale) begin
      // Stale reads leave the buffer bus untouched.
      frame_num_d = rd_frame_num;
      offset_0_d  = rd_offset_0;
      offset_1_d  = rd_offset_1;
    end
  end

  // --------------------------------------------------------------------------
  // Read response
  // --------------------------------------------------------------------------
  always_comb begin
    rd_p1_err_d = rd_gnt & rd_stale;
    rd_err_d    = rd_err_q;
    rd_data_0_d = rd_data_0_q;
    rd_data_1_d = rd_data_1_q;
    if (rd_p1_q) begin
      rd_err_d    = rd_p1_err_q;
      rd_data_0_d = rd_p1_err_q ? '0 : data_out_0;
      rd_data_1_d = rd_p1_err_q ? '0 : data_out_1;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      cur_frame_q <= '0;
      wr_ptr_q    <= '0;
      wr_full_q   <= 1'b0;
      hist_q      <= HistRst;
      starve_q    <= '0;
    end else begin
      cur_frame_q <= cur_frame_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_full_q   <= wr_full_d;
      hist_q      <= hist_d;
      starve_q    <= starve_d;
    end
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      we_q        <= 1'b0;
      frame_num_q <= '0;
      offset_0_q  <= '0;
      offset_1_q  <= '0;
      data_in_0_q <= '0;
      data_in_1_q <= '0;
    end else begin
      we_q        <= we_d;
      frame_num_q <= frame_num_d;
      offset_0_q  <= offset_0_d;
      offset_1_q  <= offset_1_d;
      data_in_0_q <= data_in_0_d;
      data_in_1_q <= data_in_1_d;
    end
  end

  // Reset clears the pipeline, so an in-flight read never produces rd_valid.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      rd_p1_q     <= 1'b0;
      rd_p1_err_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_err_q    <= 1'b0;
      rd_data_0_q <= '0;
      rd_data_1_q <= '0;
    end else begin
      rd_p1_q     <= rd_gnt;
      rd_p1_err_q <= rd_p1_err_d;
      rd_valid_q  <= rd_p1_q;
      rd_err_q    <= rd_err_d;
      rd_data_0_q <= rd_data_0_d;
      rd_data_1_q <= rd_data_1_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign wr_full               = wr_full_q;
  assign cur_frame_num         = cur_frame_q;
  assign num_of_history_frames = hist_q;
  assign frame_num             = frame_num_q;
  assign offset_0              = offset_0_q;
  assign offset_1              = offset_1_q;
  assign data_in_0             = data_in_0_q;
  assign data_in_1             = data_in_1_q;
  assign we                    = we_q;
  assign rd_valid              = rd_valid_q;
  assign rd_err                = rd_err_q;
  assign rd_data_0             = rd_data_0_q;
  assign rd_data_1             = rd_data_1_q;

endmodule
